// File: rtl/pwm_div_cfg_arbiter.sv
// pwm_div_cfg_arbiter
// Round-robin arbiter that lets NUM_REQ requesters change the odd/even divide
// values of the PWM clock divider. Each request is validated, then applied
// only at a common period boundary of both divided clocks (or after MAX_WAIT
// cycles), together with a one-cycle div_rst that re-phases the divider.
//
// Handshake: req_valid[i] is held by the requester until req_ready[i]; a
// transfer happens on a clock edge where req_valid[i] & req_ready[i]. At most
// one req_ready bit is set, and only while the FSM is IDLE. Completion is a
// one-cycle done_valid[g] pulse to the granted requester, qualified by done_err.
module pwm_div_cfg_arbiter #(
    parameter int RANGE_CLK_DIV = 12,
    parameter int NUM_REQ       = 4,
    parameter int DEF_ODD       = 5,
    parameter int DEF_EVEN      = 4,
    parameter int MAX_WAIT      = 256
) (
    input  logic                             clk_in,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*RANGE_CLK_DIV-1:0] req_odd,
    input  logic [NUM_REQ*RANGE_CLK_DIV-1:0] req_even,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               done_valid,
    output logic                             done_err,
    output logic [RANGE_CLK_DIV-1:0]         clk_divider_odd,
    output logic [RANGE_CLK_DIV-1:0]         clk_divider_even,
    output logic                             div_rst,
    output logic                             busy
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [RANGE_CLK_DIV-1:0] ONE = RANGE_CLK_DIV'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_APPLY,
        S_RESP
    } state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         cap_idx;
    logic [RANGE_CLK_DIV-1:0] cap_odd, cap_even;
    logic                     err_q;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [RANGE_CLK_DIV-1:0] odd_ph, even_ph;
    logic [RANGE_CLK_DIV-1:0] div_odd, div_even;
    logic                     div_rst_q;

    logic [NUM_REQ-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     found;
    int                       cand;
    logic                     cfg_ok, cfg_same, boundary, apply_now;

    // Rotating-priority search for the first pending request at or above rr_ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    assign req_ready = (state == S_IDLE) ? grant : '0;

    // Odd value must be odd and >=3, even value even and >=2; this also keeps value-1 from underflowing.
    assign cfg_ok   = cap_odd[0] && (cap_odd >= RANGE_CLK_DIV'(3)) &&
                      !cap_even[0] && (cap_even >= RANGE_CLK_DIV'(2));
    assign cfg_same = (cap_odd == div_odd) && (cap_even == div_even);
    assign boundary = (odd_ph == div_odd - ONE) && (even_ph == div_even - ONE);

    // Next-state logic and the RESP-state completion pulse.
    always_comb begin
        state_n    = state;
        done_valid = '0;
        case (state)
            S_IDLE:  if (found) state_n = S_CHECK;
            S_CHECK: begin
                if (!cfg_ok || cfg_same) state_n = S_RESP;
                else                     state_n = S_WAIT;
            end
            S_WAIT:  begin
                if (boundary || (wait_cnt == WAIT_W'(MAX_WAIT - 1))) state_n = S_APPLY;
            end
            S_APPLY: state_n = S_RESP;
            S_RESP:  begin
                done_valid[cap_idx] = 1'b1;
                state_n             = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign apply_now = (state == S_WAIT) && (state_n == S_APPLY);
    assign done_err  = (state == S_RESP) && err_q;
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Request capture, round-robin pointer, wait counter and the active divide values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rr_ptr    <= '0;
            cap_idx   <= '0;
            cap_odd   <= '0;
            cap_even  <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
            div_odd   <= RANGE_CLK_DIV'(DEF_ODD);
            div_even  <= RANGE_CLK_DIV'(DEF_EVEN);
            div_rst_q <= 1'b0;
        end else begin
            div_rst_q <= apply_now;
            if (state == S_IDLE && found) begin
                cap_idx  <= grant_idx;
                cap_odd  <= req_odd[int'(grant_idx)*RANGE_CLK_DIV +: RANGE_CLK_DIV];
                cap_even <= req_even[int'(grant_idx)*RANGE_CLK_DIV +: RANGE_CLK_DIV];
                rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == S_CHECK) begin
                err_q    <= !cfg_ok;
                wait_cnt <= '0;
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (apply_now) begin
                div_odd  <= cap_odd;
                div_even <= cap_even;
            end
        end
    end

    // Phase counters of both divided clocks; realigned to 0 when new values take effect.
    always_ff @(posedge clk_in) begin
        if (rst || apply_now) begin
            odd_ph  <= '0;
            even_ph <= '0;
        end else begin
            odd_ph  <= (odd_ph == div_odd - ONE) ? '0 : odd_ph + ONE;
            even_ph <= (even_ph == div_even - ONE) ? '0 : even_ph + ONE;
        end
    end

    assign clk_divider_odd  = div_odd;
    assign clk_divider_even = div_even;
    assign div_rst          = div_rst_q;

endmodule

// File: tb/tb_pwm_div_cfg_arbiter.sv
// tb_pwm_div_cfg_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level model
// predicts, for every granted request, the cycle of div_rst, of the value
// change and of done_valid, using modular arithmetic on elapsed cycles for the
// period boundaries; every output is compared every cycle.
module tb_pwm_div_cfg_arbiter;
    localparam int R  = 12;
    localparam int N  = 4;
    localparam int MW = 8;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*R-1:0]   req_odd   = '0;
    logic [N*R-1:0]   req_even  = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     done_valid;
    logic             done_err;
    logic [R-1:0]     clk_divider_odd;
    logic [R-1:0]     clk_divider_even;
    logic             div_rst;
    logic             busy;

    pwm_div_cfg_arbiter #(
        .RANGE_CLK_DIV(R), .NUM_REQ(N), .DEF_ODD(5), .DEF_EVEN(4), .MAX_WAIT(MW)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .req_valid(req_valid), .req_odd(req_odd), .req_even(req_even),
        .req_ready(req_ready), .done_valid(done_valid), .done_err(done_err),
        .clk_divider_odd(clk_divider_odd), .clk_divider_even(clk_divider_even),
        .div_rst(div_rst), .busy(busy)
    );

    // Clock.
    always #5 clk_in = ~clk_in;

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state.
    int act_odd, act_even, ph_base;
    int apply_cyc, done_cyc, done_idx, idle_from, rr;
    int new_odd, new_even;
    bit exp_err;

    // Requester state.
    bit want[N];
    int r_odd[N], r_even[N];
    bit rnd_en = 1'b0;

    // Observations of the DUT used by directed checks.
    int n_div_rst = 0, last_div_rst_cyc = -1;
    int n_done = 0, last_done_cyc = -1;
    bit last_done_err = 1'b0;
    int last_grant_cyc = -1, last_grant_idx = -1;
    int grant_log[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_bnd(input int c);
        return (((c - ph_base) % act_odd) == act_odd - 1) &&
               (((c - ph_base) % act_even) == act_even - 1);
    endfunction

    function automatic void pick(output int o, output int e);
        case ($urandom_range(0, 9))
            0: begin
                o = ($urandom_range(0, 1) == 1) ? 1 : 2 * int'($urandom_range(1, 6));
                e = 2 * int'($urandom_range(1, 5));
            end
            1: begin
                o = 2 * int'($urandom_range(1, 5)) + 1;
                e = ($urandom_range(0, 1) == 1) ? 0 : 2 * int'($urandom_range(0, 5)) + 1;
            end
            2: begin
                o = act_odd;
                e = act_even;
            end
            3: begin
                o = 4095;
                e = 4094 - 2 * int'($urandom_range(0, 3));
            end
            default: begin
                o = 2 * int'($urandom_range(1, 6)) + 1;
                e = 2 * int'($urandom_range(1, 6));
            end
        endcase
    endfunction

    task automatic drive_vectors();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = want[i];
            req_odd[i*R +: R]   = R'(r_odd[i]);
            req_even[i*R +: R]  = R'(r_even[i]);
        end
    endtask

    task automatic drive_inputs();
        if (rnd_en) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                    pick(r_odd[i], r_even[i]);
                end else if (want[i] && $urandom_range(0, 31) == 0) begin
                    want[i] = 1'b0;
                end
            end
        end
        drive_vectors();
    endtask

    task automatic schedule(input int g);
        int o, e, w;
        bit bad;
        o = r_odd[g];
        e = r_even[g];
        rr = (g + 1) % N;
        done_idx = g;
        last_grant_cyc = cyc;
        last_grant_idx = g;
        grant_log.push_back(g);
        want[g] = 1'b0;
        bad = (o % 2 == 0) || (o < 3) || (e % 2 == 1) || (e < 2);
        if (bad || (o == act_odd && e == act_even)) begin
            exp_err   = bad;
            done_cyc  = cyc + 2;
            idle_from = cyc + 3;
        end else begin
            w = 0;
            while (w < MW - 1 && !is_bnd(cyc + 2 + w)) w++;
            new_odd   = o;
            new_even  = e;
            exp_err   = 1'b0;
            apply_cyc = cyc + 3 + w;
            done_cyc  = cyc + 4 + w;
            idle_from = cyc + 5 + w;
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_done, exp_rdy;
        bit exp_busy;
        int g, idx;
        if (cyc == apply_cyc) begin
            act_odd  = new_odd;
            act_even = new_even;
            ph_base  = cyc;
        end
        exp_busy = (cyc < idle_from);
        chk("odd", clk_divider_odd, act_odd);
        chk("even", clk_divider_even, act_even);
        chk("div_rst", div_rst, (cyc == apply_cyc));
        chk("busy", busy, exp_busy);
        exp_done = '0;
        if (cyc == done_cyc) exp_done[done_idx] = 1'b1;
        chk("done_valid", done_valid, exp_done);
        if (cyc == done_cyc) chk("done_err", done_err, exp_err);
        g = -1;
        if (!exp_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && want[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (div_rst) begin
            n_div_rst++;
            last_div_rst_cyc = cyc;
        end
        if (|done_valid) begin
            n_done++;
            last_done_cyc = cyc;
            last_done_err = done_err;
        end
        if (g >= 0) schedule(g);
    endtask

    task automatic step();
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        drive_inputs();
        #1;
        check_cycle();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        rst = 1'b1;
        for (int i = 0; i < N; i++) want[i] = 1'b0;
        drive_vectors();
        repeat (n) begin
            @(posedge clk_in);
            cyc++;
        end
        @(negedge clk_in);
        rst       = 1'b0;
        act_odd   = 5;
        act_even  = 4;
        ph_base   = cyc;
        apply_cyc = -1;
        done_cyc  = -1;
        idle_from = cyc;
        rr        = 0;
        #1;
        chk("reset_done_err", done_err, 0);
        check_cycle();
    endtask

    task automatic run_until_quiet(input int budget);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            pend = (cyc < idle_from);
            for (int i = 0; i < N; i++) if (want[i]) pend = 1'b1;
            if (pend) begin
                step();
                n++;
            end
        end
        if (pend) chk("quiet_timeout", 0, 1);
    endtask

    task automatic set_req(input int i, input int o, input int e);
        want[i]  = 1'b1;
        r_odd[i] = o;
        r_even[i] = e;
    endtask

    initial begin
        int base_rst, base_done, t;
        bit reraised;
        int exp_order[5];
        for (int i = 0; i < N; i++) begin
            want[i] = 1'b0;
            r_odd[i] = 0;
            r_even[i] = 0;
        end

        // Reset for three cycles; defaults checked inside do_reset.
        do_reset(3);

        // Apply 7/6 from 5/4, issued so the first common boundary falls inside the wait window.
        repeat (11) step();
        set_req(0, 7, 6);
        step();
        chk("t2_grant0", last_grant_idx, 0);
        t = last_grant_cyc;
        run_until_quiet(60);
        chk("t2_div_rst_lat", last_div_rst_cyc - t, 8);
        chk("t2_within20", ((last_div_rst_cyc - t) <= 20), 1);
        chk("t2_odd", clk_divider_odd, 7);
        chk("t2_even", clk_divider_even, 6);
        chk("t2_done_err", last_done_err, 0);

        // Invalid odd value from requester 1.
        base_rst = n_div_rst;
        set_req(1, 4, 6);
        step();
        t = last_grant_cyc;
        run_until_quiet(20);
        chk("t3_err", last_done_err, 1);
        chk("t3_done_lat", last_done_cyc - t, 2);
        chk("t3_no_div_rst", n_div_rst - base_rst, 0);
        chk("t3_odd_kept", clk_divider_odd, 7);

        // All four requesters held: grant order 0,1,2,3 then 0 again.
        do_reset(2);
        grant_log.delete();
        base_rst = n_div_rst;
        set_req(0, 3, 2);
        set_req(1, 7, 4);
        set_req(2, 9, 6);
        set_req(3, 5, 2);
        reraised = 1'b0;
        for (int n = 0; n < 200 && grant_log.size() < 5; n++) begin
            step();
            if (!reraised && grant_log.size() == 1) begin
                set_req(0, 11, 8);
                reraised = 1'b1;
            end
        end
        run_until_quiet(60);
        exp_order = '{0, 1, 2, 3, 0};
        chk("t4_grants", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk($sformatf("t4_order%0d", i), grant_log[i], exp_order[i]);
        end
        chk("t4_div_rst_count", n_div_rst - base_rst, 5);

        // Forced apply of 4095/4094 right after reset: no boundary within the wait window.
        do_reset(2);
        set_req(0, 4095, 4094);
        step();
        t = last_grant_cyc;
        run_until_quiet(40);
        chk("t5_forced_lat", last_div_rst_cyc - t, MW + 2);
        chk("t5_odd", clk_divider_odd, 4095);
        chk("t5_even", clk_divider_even, 4094);

        // Reset in the middle of WAIT: no completion, defaults back, next request serviced.
        do_reset(2);
        set_req(2, 9, 8);
        step();
        repeat (3) step();
        chk("t6_busy_in_wait", busy, 1);
        do_reset(2);
        base_done = n_done;
        repeat (12) step();
        chk("t6_no_done", n_done - base_done, 0);
        chk("t6_odd_def", clk_divider_odd, 5);
        chk("t6_even_def", clk_divider_even, 4);
        set_req(1, 3, 2);
        step();
        run_until_quiet(40);
        chk("t6_next_grant", last_grant_idx, 1);
        chk("t6_odd_new", clk_divider_odd, 3);
        chk("t6_even_new", clk_divider_even, 2);

        // Randomized traffic with occasional resets.
        rnd_en = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
            else step();
        end
        rnd_en = 1'b0;
        run_until_quiet(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
